sevenseg_monitor: RTL and testbench

- Observes the six active-low 7-segment buses driven by the stopwatch display (hex5..hex0, format mm:ss:cc) and decodes them back to BCD.
- Filters transient segment glitches and converts each stable frame to a binary centisecond count.
- Flags illegal patterns, out-of-range digits and backward time steps.
- Sits beside the stopwatch as an on-board self-check; the same block serves as the display checker in benches.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_decode.sv | 27 ++
 rtl/sevenseg_monitor.sv | 156 +++++++++++++++
 tb/tb_sevenseg_monitor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, digit codes, frame classes and BCD-to-centisecond helper
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_BAD   = 4'hE;

  localparam int CS_W = 19;

  localparam logic [CS_W-1:0] W_MIN = 19'd6000;
  localparam logic [CS_W-1:0] W_SEC = 19'd100;
  localparam logic [CS_W-1:0] W_TEN = 19'd10;

  typedef enum logic {IDLE, TRACK} mon_state_t;

  typedef enum logic [1:0] {CLS_BAD, CLS_BLANK, CLS_RANGE, CLS_VALID} frame_class_t;

  // Only meaningful for range-checked frames; larger inputs may wrap.
  function automatic logic [CS_W-1:0] bcd_to_cs(input logic [23:0] d);
    logic [CS_W-1:0] mm;
    logic [CS_W-1:0] ss;
    logic [CS_W-1:0] cc;
    mm = CS_W'(d[23:20]) * W_TEN + CS_W'(d[19:16]);
    ss = CS_W'(d[15:12]) * W_TEN + CS_W'(d[11:8]);
    cc = CS_W'(d[7:4])   * W_TEN + CS_W'(d[3:0]);
    return mm * W_MIN + ss * W_SEC + cc;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - inverse of the active-low gfedcba digit encoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit
);

  always_comb begin
    digit = DIG_BAD;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = DIG_BLANK;
      default:   digit = DIG_BAD;
    endcase
  end

endmodule

// File: rtl/sevenseg_monitor.sv
// rtl/sevenseg_monitor.sv - stopwatch display checker: glitch filter, decode, convert, error flags
module sevenseg_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
)
(
  input  logic            clk,
  input  logic            key_reset,
  input  logic [6:0]      hex0,
  input  logic [6:0]      hex1,
  input  logic [6:0]      hex2,
  input  logic [6:0]      hex3,
  input  logic [6:0]      hex4,
  input  logic [6:0]      hex5,
  input  logic            err_clear,
  output logic [23:0]     bcd_value,
  output logic [CS_W-1:0] cs_value,
  output logic            frame_update,
  output logic            frame_blank,
  output logic            err_invalid,
  output logic            err_range,
  output logic            err_backward,
  output logic [15:0]     frame_count
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [41:0]      hex_in;
  logic [41:0]      samp_q;
  logic [CNT_W-1:0] stab_cnt;
  logic [23:0]      frame;
  logic             commit;
  logic             commit_q;
  logic             fresh_q;

  mon_state_t   state;
  mon_state_t   state_next;
  frame_class_t frame_class;
  logic [CS_W-1:0] new_cs;
  logic         set_invalid;
  logic         set_range;
  logic         set_backward;
  logic         any_bad;
  logic         any_blank;

  assign hex_in = {hex5, hex4, hex3, hex2, hex1, hex0};

  for (genvar i = 0; i < 6; i++) begin : g_dec
    seg7_decode u_dec (
      .seg   (samp_q[7*i +: 7]),
      .digit (frame[4*i +: 4])
    );
  end

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      samp_q   <= '1;
      stab_cnt <= '0;
    end else begin
      samp_q <= hex_in;
      if (hex_in != samp_q) begin
        stab_cnt <= CNT_W'(1);
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
    end
  end

  // fresh_q lets the very first stable frame commit even if it matches the reset bcd_value.
  assign commit = (stab_cnt == CNT_MAX) && ((frame != bcd_value) || fresh_q);

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      bcd_value <= 24'hFFFFFF;
      commit_q  <= 1'b0;
      fresh_q   <= 1'b1;
    end else begin
      commit_q <= commit;
      if (commit) begin
        bcd_value <= frame;
        fresh_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    any_bad      = 1'b0;
    any_blank    = 1'b0;
    set_invalid  = 1'b0;
    set_range    = 1'b0;
    set_backward = 1'b0;
    new_cs       = bcd_to_cs(bcd_value);
    for (int i = 0; i < 6; i++) begin
      if (bcd_value[4*i +: 4] == DIG_BAD)   any_bad   = 1'b1;
      if (bcd_value[4*i +: 4] == DIG_BLANK) any_blank = 1'b1;
    end
    if (any_bad) begin
      frame_class = CLS_BAD;
    end else if (any_blank) begin
      frame_class = CLS_BLANK;
    end else if ((bcd_value[23:20] > 4'd5) || (bcd_value[15:12] > 4'd5)) begin
      frame_class = CLS_RANGE;
    end else begin
      frame_class = CLS_VALID;
    end
    if (commit_q) begin
      set_invalid = (frame_class == CLS_BAD);
      set_range   = (frame_class == CLS_RANGE);
      if (frame_class == CLS_VALID) begin
        // A return to zero is a legitimate reset or hour wrap.
        set_backward = (state == TRACK) && (new_cs < cs_value) && (new_cs != '0);
        state_next   = TRACK;
      end
    end
  end

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      cs_value     <= '0;
      frame_count  <= '0;
      frame_update <= 1'b0;
      frame_blank  <= 1'b0;
      err_invalid  <= 1'b0;
      err_range    <= 1'b0;
      err_backward <= 1'b0;
    end else begin
      frame_update <= commit_q;
      err_invalid  <= (err_invalid  & ~err_clear) | set_invalid;
      err_range    <= (err_range    & ~err_clear) | set_range;
      err_backward <= (err_backward & ~err_clear) | set_backward;
      if (commit_q) begin
        if (frame_class == CLS_BLANK) begin
          frame_blank <= 1'b1;
        end else if (frame_class == CLS_VALID) begin
          frame_blank <= 1'b0;
          cs_value    <= new_cs;
          if (frame_count != 16'hFFFF) begin
            frame_count <= frame_count + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_monitor.sv
// tb/tb_sevenseg_monitor.sv - self-checking bench for sevenseg_monitor
module tb_sevenseg_monitor;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        key_reset = 1'b1;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        err_clear;
  logic [23:0] bcd_value;
  logic [18:0] cs_value;
  logic        frame_update, frame_blank, err_invalid, err_range, err_backward;
  logic [15:0] frame_count;
  logic [41:0] hexbus;

  int checks = 0;
  int failures = 0;
  bit checking = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  sevenseg_monitor #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .key_reset(key_reset),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .err_clear(err_clear), .bcd_value(bcd_value), .cs_value(cs_value),
    .frame_update(frame_update), .frame_blank(frame_blank),
    .err_invalid(err_invalid), .err_range(err_range), .err_backward(err_backward),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  assign hexbus = {hex5, hex4, hex3, hex2, hex1, hex0};

  function automatic logic [3:0] dig(input logic [6:0] seg);
    for (int d = 0; d < 10; d++) if (seg == seg_tab[d]) return 4'(d);
    if (seg == 7'h7F) return 4'hF;
    return 4'hE;
  endfunction

  function automatic logic [23:0] frame_of(input logic [41:0] s);
    logic [23:0] f;
    for (int i = 0; i < 6; i++) f[4*i +: 4] = dig(s[7*i +: 7]);
    return f;
  endfunction

  // Reference model: frames, classification and time arithmetic at the level of the display rules.
  logic [41:0] m_prev;
  int          m_run, m_cs, m_count;
  bit          m_first, m_pend, m_upd, m_blank, m_inv, m_rng, m_bwd, m_track;
  logic [23:0] m_bcd, m_pframe;

  always @(posedge clk or negedge key_reset) begin
    int d [6];
    int v;
    bit s_inv, s_rng, s_bwd, has_bad, has_blank;
    if (!key_reset) begin
      m_prev = '1; m_run = 0; m_cs = 0; m_count = 0; m_first = 1; m_pend = 0; m_upd = 0;
      m_blank = 0; m_inv = 0; m_rng = 0; m_bwd = 0; m_track = 0; m_bcd = 24'hFFFFFF; m_pframe = '0;
    end else begin
      s_inv = 0; s_rng = 0; s_bwd = 0; has_bad = 0; has_blank = 0;
      m_upd = m_pend;
      if (m_pend) begin
        for (int i = 0; i < 6; i++) begin
          d[i] = int'(m_pframe[4*i +: 4]);
          if (d[i] == 14) has_bad = 1;
          if (d[i] == 15) has_blank = 1;
        end
        if (has_bad) s_inv = 1;
        else if (has_blank) m_blank = 1;
        else if (d[5] > 5 || d[3] > 5) s_rng = 1;
        else begin
          v = ((d[5] * 10 + d[4]) * 60 + d[3] * 10 + d[2]) * 100 + d[1] * 10 + d[0];
          if (m_track && v < m_cs && v != 0) s_bwd = 1;
          m_cs = v;
          if (m_count < 65535) m_count++;
          m_blank = 0;
          m_track = 1;
        end
      end
      m_inv = (m_inv && !err_clear) || s_inv;
      m_rng = (m_rng && !err_clear) || s_rng;
      m_bwd = (m_bwd && !err_clear) || s_bwd;
      m_pend = 0;
      if (m_run >= S && (frame_of(m_prev) != m_bcd || m_first)) begin
        m_bcd = frame_of(m_prev);
        m_pframe = m_bcd;
        m_pend = 1;
        m_first = 0;
      end
      if (hexbus != m_prev) m_run = 1;
      else if (m_run < S) m_run++;
      m_prev = hexbus;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("bcd_value",    32'(bcd_value),    32'(m_bcd));
      chk("cs_value",     32'(cs_value),     32'(m_cs));
      chk("frame_update", 32'(frame_update), 32'(m_upd));
      chk("frame_blank",  32'(frame_blank),  32'(m_blank));
      chk("err_invalid",  32'(err_invalid),  32'(m_inv));
      chk("err_range",    32'(err_range),    32'(m_rng));
      chk("err_backward", 32'(err_backward), 32'(m_bwd));
      chk("frame_count",  32'(frame_count),  32'(m_count));
    end
  end

  function automatic logic [6:0] enc(input int d);
    return (d >= 0 && d < 10) ? seg_tab[d] : 7'h7F;
  endfunction

  task automatic put_digits(input int d5, input int d4, input int d3, input int d2, input int d1, input int d0);
    hex5 = enc(d5); hex4 = enc(d4); hex3 = enc(d3); hex2 = enc(d2); hex1 = enc(d1); hex0 = enc(d0);
  endtask

  task automatic put_cs(input int cs);
    int m, s, c;
    m = cs / 6000; s = (cs / 100) % 60; c = cs % 100;
    put_digits(m / 10, m % 10, s / 10, s % 10, c / 10, c % 10);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    hold(1);
    err_clear = 1'b0;
  endtask

  function automatic logic [6:0] bad_pattern();
    logic [6:0] p;
    for (int t = 0; t < 16; t++) begin
      p = 7'($urandom);
      if (dig(p) == 4'hE) return p;
    end
    return 7'b0000110;
  endfunction

  initial begin
    int lat, cnt_before, cur, kind, pos;
    bit upd_seen;
    logic [6:0] bp;
    err_clear = 1'b0;
    put_digits(-1, -1, -1, -1, -1, -1);
    #2 key_reset = 1'b0;
    hold(3);
    checking = 1;
    chk("reset_bcd", 32'(bcd_value), 32'h00FFFFFF);
    chk("reset_count", 32'(frame_count), 32'd0);

    // First frame: commit and update latency from reset release
    put_digits(0, 0, 0, 0, 0, 0);
    key_reset = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (frame_update && lat == 0) lat = i;
    end
    chk("first_update_latency", 32'(lat), 32'd6);
    chk("first_bcd", 32'(bcd_value), 32'h0);
    chk("first_cs", 32'(cs_value), 32'd0);
    chk("first_count", 32'(frame_count), 32'd1);

    put_digits(0, 1, 2, 3, 4, 5);
    hold(8);
    chk("cs_012345", 32'(cs_value), 32'd8345);
    chk("no_bwd_012345", 32'(err_backward), 32'd0);
    put_digits(0, 1, 2, 3, 4, 4);
    hold(8);
    chk("bwd_set", 32'(err_backward), 32'd1);
    chk("cs_012344", 32'(cs_value), 32'd8344);
    pulse_clear();
    hold(2);
    chk("bwd_cleared", 32'(err_backward), 32'd0);

    // Fast toggling must never satisfy the filter
    upd_seen = 0;
    for (int i = 0; i < 50; i++) begin
      hex0 = (i % 2 == 0) ? seg_tab[9] : seg_tab[0];
      @(negedge clk);
      if (frame_update) upd_seen = 1;
    end
    chk("toggle_no_update", 32'(upd_seen), 32'd0);
    chk("toggle_bcd_held", 32'(bcd_value), 32'h012344);
    put_digits(0, 1, 2, 3, 4, 4);
    hold(8);

    hex3 = 7'b0000110;
    hold(8);
    chk("bad_digit", 32'(bcd_value[15:12]), 32'hE);
    chk("invalid_set", 32'(err_invalid), 32'd1);
    chk("bad_cs_held", 32'(cs_value), 32'd8344);
    hex3 = seg_tab[5];
    hold(8);
    chk("cs_015344", 32'(cs_value), 32'd11344);
    chk("no_bwd_after_bad", 32'(err_backward), 32'd0);

    cnt_before = int'(frame_count);
    hex5 = seg_tab[6];
    hold(8);
    chk("range_set", 32'(err_range), 32'd1);
    chk("range_count_held", 32'(frame_count), 32'(cnt_before));
    pulse_clear();
    put_digits(-1, -1, -1, -1, -1, -1);
    hold(8);
    chk("blank_set", 32'(frame_blank), 32'd1);
    chk("blank_no_range", 32'(err_range), 32'd0);
    chk("blank_no_invalid", 32'(err_invalid), 32'd0);

    // Asynchronous reset in the middle of the filter window
    put_digits(0, 0, 1, 2, 0, 0);
    hold(2);
    #2 key_reset = 1'b0;
    #1;
    chk("async_bcd", 32'(bcd_value), 32'h00FFFFFF);
    chk("async_cs", 32'(cs_value), 32'd0);
    chk("async_count", 32'(frame_count), 32'd0);
    chk("async_blank", 32'(frame_blank), 32'd0);
    chk("async_update", 32'(frame_update), 32'd0);
    @(negedge clk);
    key_reset = 1'b1;
    put_digits(0, 0, 0, 0, 0, 1);
    hold(10);
    chk("post_reset_cs", 32'(cs_value), 32'd1);
    chk("post_reset_bwd", 32'(err_backward), 32'd0);
    chk("post_reset_count", 32'(frame_count), 32'd1);

    // Randomized mix of progressing time, glitches, bad, blank and out-of-range frames
    cur = 1;
    for (int n = 0; n < 1500; n++) begin
      kind = int'($urandom_range(0, 11));
      if (kind <= 5) begin
        if ($urandom_range(0, 15) == 0) cur = int'($urandom_range(0, 359999));
        else if ($urandom_range(0, 31) == 0) cur = 0;
        else cur = (cur + int'($urandom_range(0, 300))) % 360000;
        put_cs(cur);
        hold(($urandom_range(0, 2) == 0) ? S : int'($urandom_range(1, 8)));
      end else if (kind <= 7) begin
        put_cs(int'($urandom_range(0, 359999)));
        hold(int'($urandom_range(1, S - 1)));
      end else if (kind == 8) begin
        put_cs(cur);
        pos = int'($urandom_range(0, 5));
        bp = bad_pattern();
        hexbus_set(pos, bp);
        hold(int'($urandom_range(1, 8)));
      end else if (kind == 9) begin
        put_cs(cur);
        hexbus_set(int'($urandom_range(0, 5)), 7'h7F);
        hold(int'($urandom_range(1, 8)));
      end else if (kind == 10) begin
        put_cs(cur);
        if ($urandom_range(0, 1) == 0) hex5 = enc(int'($urandom_range(6, 9)));
        else hex3 = enc(int'($urandom_range(6, 9)));
        hold(int'($urandom_range(1, 8)));
      end else begin
        err_clear = 1'b1;
        hold(int'($urandom_range(1, 2)));
        err_clear = 1'b0;
      end
    end
    hold(10);
    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic hexbus_set(input int pos, input logic [6:0] p);
    case (pos)
      0: hex0 = p;
      1: hex1 = p;
      2: hex2 = p;
      3: hex3 = p;
      4: hex4 = p;
      default: hex5 = p;
    endcase
  endtask

endmodule
